// File: rtl/phrase_reader_pkg.sv
// Shared types and constants for the phrase reader: FSM state encoding,
// default RAM size and the widths used on the RAM and length paths.
package phrase_reader_pkg;

    localparam int DEFAULT_RAM_DEPTH = 328;
    localparam int ADDR_W            = 32;
    localparam int LEN_W             = 9;
    localparam int CHAR_W            = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SEND,
        FIN
    } state_t;

endpackage

// File: rtl/phrase_reader_if.sv
// Bus bundle for the phrase reader: the read-only RAM port on one side and
// the valid/ready character stream on the other.
interface phrase_reader_if;
    import phrase_reader_pkg::*;

    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic [31:0]       ram_q;
    logic [CHAR_W-1:0] char_data;
    logic              char_valid;
    logic              char_ready;

    modport master (
        output ram_address,
        output ram_wren,
        output char_data,
        output char_valid,
        input  ram_q,
        input  char_ready
    );

    modport slave (
        input  ram_address,
        input  ram_wren,
        input  char_data,
        input  char_valid,
        output ram_q,
        output char_ready
    );

endinterface

// File: rtl/phrase_reader.sv
// Streams the low byte of consecutive RAM words as characters until the
// requested length is reached or the terminator byte is read.
module phrase_reader
    import phrase_reader_pkg::*;
#(
    parameter int          RAM_DEPTH = DEFAULT_RAM_DEPTH,
    parameter logic [7:0]  TERM_CHAR = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    phrase_reader_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  count
);

    localparam logic [ADDR_W-1:0] DEPTH     = ADDR_W'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pointer;
    logic [ADDR_W-1:0] pointer_next;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_next;
    logic [ADDR_W-1:0] address_q;
    logic [ADDR_W-1:0] address_next;
    logic [CHAR_W-1:0] data_q;
    logic [CHAR_W-1:0] data_next;
    logic              valid_q;
    logic              valid_next;
    logic              busy_next;
    logic              done_next;
    logic              err_next;
    logic [LEN_W-1:0]  count_next;
    logic              unused_ram_bits;

    assign unused_ram_bits = ^bus.ram_q[31:8];

    assign bus.ram_address = address_q;
    assign bus.ram_wren    = 1'b0;
    assign bus.char_data   = data_q;
    assign bus.char_valid  = valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pointer   <= '0;
            len_q     <= '0;
            address_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_next;
            pointer   <= pointer_next;
            len_q     <= len_next;
            address_q <= address_next;
            data_q    <= data_next;
            valid_q   <= valid_next;
            busy      <= busy_next;
            done      <= done_next;
            err       <= err_next;
            count     <= count_next;
        end
    end

    // Every output is registered from the next state, so ISSUE presents the
    // address for a full cycle and the RAM answers while in WAIT.
    always_comb begin
        state_next   = state;
        pointer_next = pointer;
        len_next     = len_q;
        address_next = address_q;
        data_next    = data_q;
        count_next   = count;
        err_next     = err;

        case (state)
            IDLE: begin
                if (start) begin
                    pointer_next = base_addr;
                    len_next     = length;
                    count_next   = '0;
                    if (length == '0 || base_addr >= DEPTH) begin
                        err_next   = 1'b1;
                        state_next = FIN;
                    end else begin
                        err_next   = 1'b0;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                data_next  = bus.ram_q[7:0];
                state_next = (bus.ram_q[7:0] == TERM_CHAR) ? FIN : SEND;
            end
            SEND: begin
                if (bus.char_ready) begin
                    count_next   = count + LEN_W'(1);
                    pointer_next = (pointer == LAST_ADDR) ? '0 : pointer + ADDR_W'(1);
                    state_next   = (count_next == len_q) ? FIN : ISSUE;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state_next == ISSUE) begin
            address_next = pointer_next;
        end
        valid_next = (state_next == SEND);
        busy_next  = (state_next == ISSUE) || (state_next == WAIT) || (state_next == SEND);
        done_next  = (state_next == FIN);
    end

endmodule
